prbs3_checker: RTL and testbench
================================

PRBS3_CHECKER -- requirements
Module: prbs3_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: number of consecutive correct predictions required in CHECK before LOCKED.
REQ-002 Parameter LOSS_THRESH, default 3: number of consecutive mismatches in LOCKED before declaring sync loss.
REQ-003 Parameter CNT_W, default 16: width of err_count.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 din_valid  input  1  qualifies din; only cycles with din_valid=1 advance the checker.
REQ-007 din  input  1  received serial bit from the 3-stage PRBS generator.
REQ-008 locked  output  1  high while the FSM is in LOCKED.
REQ-009 err  output  1  one-cycle pulse for each mismatched valid bit while in LOCKED.
REQ-010 err_count  output  CNT_W  saturating count of err pulses since reset.
REQ-011 sync_loss  output  1  one-cycle pulse on the LOCKED->HUNT transition.

Function
REQ-012 Reference recurrence SHALL be b[k] = b[k-1] XOR b[k-3], which gives period 7 and the sequence 0,0,1,1,1,0,1 repeating from generator seed 100.
REQ-013 Checker SHALL hold history h[2:0], with h[0] the newest bit; on each valid bit, h <= {h[1:0], in_bit}.
REQ-014 Prediction SHALL be pred = h[0] XOR h[2], computed from the history before the shift.
REQ-015 FSM states SHALL be HUNT, CHECK, LOCKED; all outputs SHALL be registered.
REQ-016 HUNT: in_bit = din; fill_cnt SHALL increment per valid bit, saturating at 3; no comparison is made.
REQ-017 HUNT exit: on the valid bit where fill_cnt reaches 3 and the post-shift h != 000, the FSM SHALL enter CHECK with match_cnt = 0; if h = 000, it SHALL stay in HUNT.
REQ-018 CHECK: in_bit = din; a match SHALL increment match_cnt, and a mismatch SHALL clear match_cnt and stay in CHECK.
REQ-019 CHECK: if the post-shift h = 000, the FSM SHALL go to HUNT with fill_cnt = 0.
REQ-020 CHECK->LOCKED SHALL occur on the valid bit giving the LOCK_CNT-th consecutive match; locked SHALL be high the following cycle.
REQ-021 LOCKED: in_bit = pred (flywheel), so h follows the local reference and a single flipped bit produces exactly one err.
REQ-022 LOCKED mismatch SHALL pulse err the cycle after the bit, increment miss_cnt and increment err_count; a match SHALL clear miss_cnt.
REQ-023 When miss_cnt reaches LOSS_THRESH, the FSM SHALL enter HUNT with fill_cnt = 0, clear miss_cnt, pulse sync_loss, and drop locked, all visible the next cycle.
REQ-024 err and sync_loss SHALL pulse together on the threshold bit.
REQ-025 err_count SHALL saturate at 2^CNT_W-1 and never wrap; it is cleared only by reset.
REQ-026 Cycles with din_valid=0 SHALL change no state, and err and sync_loss SHALL be 0 on those cycles.
REQ-027 No errors SHALL be counted outside LOCKED.

Reset
REQ-028 While reset=1 at a clock edge: state=HUNT, h=000, fill_cnt=0, match_cnt=0, miss_cnt=0, locked=0, err=0, sync_loss=0, err_count=0.
REQ-029 reset SHALL take priority over din_valid on the same edge, and the bit presented on that edge SHALL be discarded.
REQ-030 Reset asserted mid-lock SHALL drop locked the next cycle, with no sync_loss pulse.

Verification
REQ-031 Clean acquisition: after reset, continuous din_valid with stream 0011101... -> CHECK after valid bit 3; locked=1 the cycle after valid bit 7; err stays 0 for 100 bits; err_count=0.
REQ-032 Single error: locked, flip one bit -> exactly one err pulse; err_count=1; locked stays 1; sync_loss=0.
REQ-033 Burst loss: locked, invert 3 consecutive bits -> err pulses on all 3 (err_count=3); sync_loss pulse with the third; locked=0 next cycle; the checker then re-locks 7 valid bits after the burst ends.
REQ-034 All-zero input: din=0 continuously -> remains HUNT; locked=0; err_count=0 indefinitely.
REQ-035 Gapped valid: locked, din_valid toggling 1/0 with the correct sequence on valid cycles -> locked held, err=0; err_count and state unchanged on invalid cycles.
REQ-036 Saturation and reset: CNT_W=4, locked, alternate single errors with matches -> err_count stops at 15; reset mid-stream -> all outputs zero next cycle; re-lock follows the REQ-031 timing.

Source files
------------

// File: rtl/prbs3_checker.sv
// Self-synchronising checker for a 3-stage PRBS (b[k] = b[k-1] ^ b[k-3]).
// Acquires in HUNT/CHECK, then flywheels on its own reference while LOCKED.
module prbs3_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             sync_loss
);

  // state  | meaning
  // HUNT   | filling history from din, no comparisons
  // CHECK  | comparing din against prediction, counting consecutive matches
  // LOCKED | history follows local reference, mismatches counted as errors
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  state_t             state, state_nxt;
  logic [2:0]         h, h_nxt;
  logic [1:0]         fill_cnt, fill_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic [CNT_W-1:0]   err_count_nxt;
  logic               err_nxt, sync_loss_nxt;
  logic               pred, in_bit;

  always_comb begin
    state_nxt     = state;
    h_nxt         = h;
    fill_nxt      = fill_cnt;
    match_nxt     = match_cnt;
    miss_nxt      = miss_cnt;
    err_count_nxt = err_count;
    err_nxt       = 1'b0;
    sync_loss_nxt = 1'b0;
    pred          = h[0] ^ h[2];
    // Once locked the history runs on the prediction, so a flipped bit cannot corrupt it.
    in_bit        = (state == LOCKED) ? pred : din;

    if (din_valid) begin
      h_nxt = {h[1:0], in_bit};
      case (state)
        HUNT: begin
          if (fill_cnt != 2'd3) fill_nxt = fill_cnt + 2'd1;
          if (fill_nxt == 2'd3 && h_nxt != 3'b000) begin
            state_nxt = CHECK;
            match_nxt = '0;
          end
        end
        CHECK: begin
          if (h_nxt == 3'b000) begin
            state_nxt = HUNT;
            fill_nxt  = 2'd0;
            match_nxt = '0;
          end else if (din == pred) begin
            match_nxt = match_cnt + MATCH_W'(1);
            if (match_nxt == MATCH_W'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (din != pred) begin
            err_nxt = 1'b1;
            if (err_count != {CNT_W{1'b1}}) err_count_nxt = err_count + CNT_W'(1);
            if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
              state_nxt     = HUNT;
              fill_nxt      = 2'd0;
              miss_nxt      = '0;
              match_nxt     = '0;
              sync_loss_nxt = 1'b1;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
          fill_nxt  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      h         <= 3'b000;
      fill_cnt  <= 2'd0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      sync_loss <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      h         <= h_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      err       <= err_nxt;
      sync_loss <= sync_loss_nxt;
      err_count <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_prbs3_checker.sv
// Bench for prbs3_checker: reference model feeds a scoreboard queue, plus
// fixed-timing checks for acquisition, error, burst loss and saturation.
module tb_prbs3_checker;

  localparam int LOCK_CNT    = 4;
  localparam int LOSS_THRESH = 3;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             din_valid;
  logic             din;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic             sync_loss;

  prbs3_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .locked(locked), .err(err), .err_count(err_count), .sync_loss(sync_loss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lk;
    int er;
    int sl;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic seq [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int   gi = 0;

  // reference model state: 0 HUNT, 1 CHECK, 2 LOCKED
  int         m_state = 0;
  logic [2:0] m_h     = 3'b000;
  int         m_fill  = 0;
  int         m_match = 0;
  int         m_miss  = 0;
  int         m_cnt   = 0;
  int         m_err   = 0;
  int         m_sl    = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic d);
    logic p;
    m_err = 0;
    m_sl  = 0;
    if (r) begin
      m_state = 0; m_h = 3'b000; m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0;
    end else if (v) begin
      p = m_h[0] ^ m_h[2];
      if (m_state == 0) begin
        m_h = {m_h[1:0], d};
        if (m_fill < 3) m_fill++;
        if (m_fill == 3 && m_h != 3'b000) begin m_state = 1; m_match = 0; end
      end else if (m_state == 1) begin
        m_h = {m_h[1:0], d};
        if (m_h == 3'b000) begin m_state = 0; m_fill = 0; m_match = 0; end
        else if (d == p) begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_state = 2; m_miss = 0; end
        end else m_match = 0;
      end else begin
        m_h = {m_h[1:0], p};
        if (d != p) begin
          m_err = 1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          m_miss++;
          if (m_miss == LOSS_THRESH) begin
            m_state = 0; m_fill = 0; m_miss = 0; m_match = 0; m_sl = 1;
          end
        end else m_miss = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic d);
    exp_t e;
    @(negedge clk);
    reset = r; din_valid = v; din = d;
    model_edge(r, v, d);
    e.lk = (m_state == 2) ? 1 : 0;
    e.er = m_err;
    e.sl = m_sl;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_locked", int'(locked), e.lk);
    check("sb_err", int'(err), e.er);
    check("sb_sync_loss", int'(sync_loss), e.sl);
    check("sb_err_count", int'(err_count), e.cnt);
  endtask

  task automatic good();
    step(1'b0, 1'b1, seq[gi]);
    gi = (gi + 1) % 7;
  endtask

  task automatic flip();
    step(1'b0, 1'b1, ~seq[gi]);
    gi = (gi + 1) % 7;
  endtask

  initial begin
    reset = 1'b1; din_valid = 1'b0; din = 1'b0;

    // reset with a valid bit present: bit must be discarded
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_locked", int'(locked), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_sync_loss", int'(sync_loss), 0);

    // clean acquisition
    gi = 0;
    for (int i = 1; i <= 100; i++) begin
      good();
      if (i == 6) check("acq_not_yet_locked", int'(locked), 0);
      if (i == 7) check("acq_locked_after_bit7", int'(locked), 1);
    end
    check("acq_err_count", int'(err_count), 0);

    // single flipped bit
    flip();
    check("single_err", int'(err), 1);
    for (int i = 0; i < 10; i++) good();
    check("single_err_count", int'(err_count), 1);
    check("single_locked", int'(locked), 1);

    // three-bit burst causes sync loss
    flip();
    flip();
    check("burst_still_locked", int'(locked), 1);
    flip();
    check("burst_err3", int'(err), 1);
    check("burst_sync_loss", int'(sync_loss), 1);
    check("burst_locked_drop", int'(locked), 0);
    check("burst_err_count", int'(err_count), 4);
    for (int i = 1; i <= 7; i++) begin
      good();
      if (i == 6) check("relock_not_yet", int'(locked), 0);
      if (i == 7) check("relock_bit7", int'(locked), 1);
    end

    // gapped valid
    for (int i = 0; i < 20; i++) begin
      good();
      step(1'b0, 1'b0, 1'($urandom));
      check("gap_locked", int'(locked), 1);
      check("gap_err", int'(err), 0);
    end
    check("gap_err_count", int'(err_count), 4);

    // saturation with alternating single errors
    for (int i = 0; i < 15; i++) begin
      flip();
      good();
    end
    check("sat_err_count", int'(err_count), 15);
    check("sat_locked", int'(locked), 1);

    // reset mid-lock, then re-acquire
    step(1'b1, 1'b1, seq[gi]);
    check("midrst_locked", int'(locked), 0);
    check("midrst_sync_loss", int'(sync_loss), 0);
    check("midrst_err_count", int'(err_count), 0);
    gi = 0;
    for (int i = 1; i <= 7; i++) begin
      good();
      if (i == 6) check("midrst_relock_not_yet", int'(locked), 0);
      if (i == 7) check("midrst_relock_bit7", int'(locked), 1);
    end

    // all-zero input never locks
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0);
    check("zero_locked", int'(locked), 0);
    check("zero_err_count", int'(err_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
